// File: rtl/velocity_pi_loop_if.sv
// Duty command bus from the velocity regulator to the commutation/PWM stage.
// The regulator drives it; the PWM stage consumes it.
interface velocity_pi_loop_if #(
    parameter int DUTY_WIDTH = 10
);
    logic [DUTY_WIDTH-1:0] duty;
    logic                  direction;
    logic                  duty_valid;
    logic                  saturated;
    logic signed [15:0]    velocity;

    modport master (
        output duty,
        output direction,
        output duty_valid,
        output saturated,
        output velocity
    );

    modport slave (
        input duty,
        input direction,
        input duty_valid,
        input saturated,
        input velocity
    );
endinterface

// File: rtl/velocity_pi_loop.sv
// Velocity PI regulator: samples the encoder once per loop period and runs a
// PI update through a single shared multiplier to produce a saturated duty.
module velocity_pi_loop #(
    parameter int LOOP_PERIOD_TICKS = 50000,
    parameter int DUTY_WIDTH        = 10,
    parameter int DUTY_MAX          = 1023,
    parameter int INTEG_LIMIT       = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [15:0]         encoder_count,
    input  logic signed [15:0]  setpoint,
    input  logic [15:0]         kp,
    input  logic [15:0]         ki,
    velocity_pi_loop_if.master  out_if
);

    localparam int TW = (LOOP_PERIOD_TICKS > 1) ? $clog2(LOOP_PERIOD_TICKS) : 1;
    localparam logic [TW-1:0]        TIMER_LAST = TW'(LOOP_PERIOD_TICKS - 1);
    localparam logic signed [24:0]   INTEG_POS  = 25'(INTEG_LIMIT);
    localparam logic signed [24:0]   INTEG_NEG  = -25'(INTEG_LIMIT);
    localparam logic [41:0]          DUTY_MAX_W = 42'(DUTY_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_ERROR,
        ST_MUL_P,
        ST_MUL_I,
        ST_SUM,
        ST_SAT
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [15:0]             prev_count_q, prev_count_d;
    logic signed [15:0]      velocity_q, velocity_d;
    logic signed [15:0]      error_q, error_d;
    logic signed [23:0]      integ_q, integ_d;
    logic signed [40:0]      p_reg_q, p_reg_d;
    logic signed [40:0]      i_reg_q, i_reg_d;
    logic signed [41:0]      sum_q, sum_d;
    logic [DUTY_WIDTH-1:0]   duty_q, duty_d;
    logic                    direction_q, direction_d;
    logic                    saturated_q, saturated_d;
    logic                    duty_valid_q, duty_valid_d;

    logic                    tick;
    logic signed [16:0]      err_wide;
    logic signed [15:0]      err_sat;
    logic signed [24:0]      integ_sum;
    logic signed [24:0]      integ_clamped;
    logic                    integ_hold;
    logic signed [40:0]      mul_a;
    logic signed [40:0]      mul_b;
    logic signed [40:0]      product;
    logic signed [41:0]      pi_total;
    logic [41:0]             sum_mag;
    logic                    sum_over;

    assign tick = (timer_q == TIMER_LAST);

    // The one multiplier: gains are unsigned Q8.8 so they are zero-extended,
    // the error/integrator operand is sign-extended; the state picks the pair.
    assign mul_a   = (state_q == ST_MUL_I) ? {25'd0, ki} : {25'd0, kp};
    assign mul_b   = (state_q == ST_MUL_I) ? 41'(integ_q) : 41'(error_q);
    assign product = mul_a * mul_b;

    always_comb begin
        err_wide = 17'(setpoint) - 17'(velocity_q);
        if (err_wide[16] != err_wide[15]) begin
            err_sat = err_wide[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            err_sat = err_wide[15:0];
        end

        integ_sum = 25'(integ_q) + 25'(err_sat);
        if (integ_sum > INTEG_POS) begin
            integ_clamped = INTEG_POS;
        end else if (integ_sum < INTEG_NEG) begin
            integ_clamped = INTEG_NEG;
        end else begin
            integ_clamped = integ_sum;
        end

        // Anti-windup: stop integrating while clipped if the error would push further the same way.
        integ_hold = saturated_q && (err_sat[15] == direction_q);

        pi_total = 42'(p_reg_q) + 42'(i_reg_q);
        sum_mag  = sum_q[41] ? 42'(-sum_q) : 42'(sum_q);
        sum_over = (sum_mag > DUTY_MAX_W);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        prev_count_d = prev_count_q;
        velocity_d   = velocity_q;
        error_d      = error_q;
        integ_d      = integ_q;
        p_reg_d      = p_reg_q;
        i_reg_d      = i_reg_q;
        sum_d        = sum_q;
        duty_d       = duty_q;
        direction_d  = direction_q;
        saturated_d  = saturated_q;
        duty_valid_d = 1'b0;

        if (!enable) begin
            // Disabled: everything idles and prev_count follows the encoder so
            // the first sample after enable measures only motion since then.
            state_d      = ST_IDLE;
            timer_d      = '0;
            prev_count_d = encoder_count;
            velocity_d   = '0;
            error_d      = '0;
            integ_d      = '0;
            p_reg_d      = '0;
            i_reg_d      = '0;
            sum_d        = '0;
            duty_d       = '0;
            direction_d  = 1'b0;
            saturated_d  = 1'b0;
        end else begin
            timer_d = tick ? '0 : timer_q + TW'(1);

            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    velocity_d   = $signed(encoder_count - prev_count_q);
                    prev_count_d = encoder_count;
                    state_d      = ST_ERROR;
                end
                ST_ERROR: begin
                    error_d = err_sat;
                    if (!integ_hold) begin
                        integ_d = 24'(integ_clamped);
                    end
                    state_d = ST_MUL_P;
                end
                ST_MUL_P: begin
                    p_reg_d = product;
                    state_d = ST_MUL_I;
                end
                ST_MUL_I: begin
                    i_reg_d = product;
                    state_d = ST_SUM;
                end
                ST_SUM: begin
                    sum_d   = pi_total >>> 8;
                    state_d = ST_SAT;
                end
                ST_SAT: begin
                    duty_d       = sum_over ? DUTY_WIDTH'(DUTY_MAX) : sum_mag[DUTY_WIDTH-1:0];
                    direction_d  = sum_q[41];
                    saturated_d  = sum_over;
                    duty_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            prev_count_q <= '0;
            velocity_q   <= '0;
            error_q      <= '0;
            integ_q      <= '0;
            p_reg_q      <= '0;
            i_reg_q      <= '0;
            sum_q        <= '0;
            duty_q       <= '0;
            direction_q  <= 1'b0;
            saturated_q  <= 1'b0;
            duty_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            prev_count_q <= prev_count_d;
            velocity_q   <= velocity_d;
            error_q      <= error_d;
            integ_q      <= integ_d;
            p_reg_q      <= p_reg_d;
            i_reg_q      <= i_reg_d;
            sum_q        <= sum_d;
            duty_q       <= duty_d;
            direction_q  <= direction_d;
            saturated_q  <= saturated_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    assign out_if.duty       = duty_q;
    assign out_if.direction  = direction_q;
    assign out_if.duty_valid = duty_valid_q;
    assign out_if.saturated  = saturated_q;
    assign out_if.velocity   = velocity_q;

endmodule

// File: tb/tb_velocity_pi_loop.sv
// Scoreboard bench for velocity_pi_loop: an update-level reference model
// predicts each duty command when stimulus is applied.
module tb_velocity_pi_loop;

    localparam int P           = 16;
    localparam int DUTY_WIDTH  = 10;
    localparam int DUTY_MAX    = 1023;
    localparam int INTEG_LIMIT = 1000;
    localparam int BUDGET      = 3 * P + 20;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [15:0]        encoder_count;
    logic signed [15:0] setpoint;
    logic [15:0]        kp;
    logic [15:0]        ki;

    velocity_pi_loop_if #(.DUTY_WIDTH(DUTY_WIDTH)) bus ();

    velocity_pi_loop #(
        .LOOP_PERIOD_TICKS (P),
        .DUTY_WIDTH        (DUTY_WIDTH),
        .DUTY_MAX          (DUTY_MAX),
        .INTEG_LIMIT       (INTEG_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .encoder_count (encoder_count),
        .setpoint      (setpoint),
        .kp            (kp),
        .ki            (ki),
        .out_if        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint velocity;
        longint duty;
        longint direction;
        longint saturated;
    } exp_t;

    exp_t   exp_q[$];
    int     num_compared   = 0;
    int     num_mismatched = 0;

    int     m_prev  = 0;
    longint m_integ = 0;
    bit     m_sat   = 1'b0;
    bit     m_neg   = 1'b0;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one update's inputs and predict its outcome from the algorithm.
    task automatic applyStimulus(input int sp, input int kp_v, input int ki_v, input int enc);
        logic [15:0] diff;
        longint vel, err, acc, sum, mag;
        exp_t   e;
        setpoint      = 16'(sp);
        kp            = 16'(kp_v);
        ki            = 16'(ki_v);
        encoder_count = 16'(enc);

        diff = 16'(enc - m_prev);
        vel  = longint'($signed(diff));
        err  = longint'(sp) - vel;
        if (err > 32767)  err = 32767;
        if (err < -32768) err = -32768;
        if (!(m_sat && ((err < 0) == m_neg))) begin
            acc = m_integ + err;
            if (acc > INTEG_LIMIT)  acc = INTEG_LIMIT;
            if (acc < -INTEG_LIMIT) acc = -INTEG_LIMIT;
            m_integ = acc;
        end
        sum = (longint'(kp_v) * err + longint'(ki_v) * m_integ) >>> 8;
        mag = (sum < 0) ? -sum : sum;
        m_sat  = (mag > DUTY_MAX);
        m_neg  = (sum < 0);
        m_prev = enc & 32'hFFFF;

        e.velocity  = vel;
        e.duty      = m_sat ? DUTY_MAX : mag;
        e.direction = m_neg ? 1 : 0;
        e.saturated = m_sat ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic waitForUpdate(output int cycles);
        exp_t e;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.duty_valid && cycles < BUDGET);
        if (!bus.duty_valid) begin
            checkOutput("update_timeout", longint'(bus.duty_valid), 1);
            return;
        end
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_update", longint'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("velocity",  longint'(bus.velocity),  e.velocity);
        checkOutput("duty",      longint'(bus.duty),      e.duty);
        checkOutput("direction", longint'(bus.direction), e.direction);
        checkOutput("saturated", longint'(bus.saturated), e.saturated);
    endtask

    // Disable long enough to clear the loop, park the encoder, then re-enable.
    task automatic restartLoop(input int enc);
        enable        = 1'b0;
        encoder_count = 16'(enc);
        repeat (3) @(posedge clk);
        #1;
        m_integ = 0;
        m_sat   = 1'b0;
        m_neg   = 1'b0;
        m_prev  = enc & 32'hFFFF;
        enable  = 1'b1;
    endtask

    initial begin
        int cycles;
        int seen;

        reset         = 1'b1;
        enable        = 1'b0;
        encoder_count = 16'h0000;
        setpoint      = '0;
        kp            = '0;
        ki            = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_duty",       longint'(bus.duty),       0);
        checkOutput("reset_direction",  longint'(bus.direction),  0);
        checkOutput("reset_saturated",  longint'(bus.saturated),  0);
        checkOutput("reset_duty_valid", longint'(bus.duty_valid), 0);
        checkOutput("reset_velocity",   longint'(bus.velocity),   0);

        // Proportional only, plus first-update latency, period and pulse width.
        restartLoop(16'h1234);
        applyStimulus(100, 16'h0100, 0, 16'h1234);
        waitForUpdate(cycles);
        checkOutput("first_update_latency", longint'(cycles), P + 6);
        applyStimulus(100, 16'h0100, 0, 16'h1234);
        waitForUpdate(cycles);
        checkOutput("update_period", longint'(cycles), P);
        @(posedge clk);
        #1;
        checkOutput("duty_valid_width", longint'(bus.duty_valid), 0);

        // Encoder wrap-around in both directions.
        restartLoop(16'hFFF0);
        applyStimulus(32, 16'h0100, 0, 16'h0010);
        waitForUpdate(cycles);
        applyStimulus(32, 16'h0100, 0, 16'hFFE0);
        waitForUpdate(cycles);

        // Reverse direction.
        restartLoop(16'h0500);
        applyStimulus(-50, 16'h0200, 0, 16'h0500);
        waitForUpdate(cycles);

        // Error saturates to +32767 when setpoint minus a negative velocity overflows.
        restartLoop(16'h0000);
        applyStimulus(32767, 16'h0001, 0, 16'hFFF6);
        waitForUpdate(cycles);

        // Saturation with anti-windup: integrator must hold at 500, giving 499 afterwards.
        restartLoop(16'h0100);
        applyStimulus(500, 16'h0300, 1, 16'h0100);
        waitForUpdate(cycles);
        applyStimulus(500, 16'h0300, 1, 16'h0100);
        waitForUpdate(cycles);
        applyStimulus(-1, 0, 16'h0100, 16'h0100);
        waitForUpdate(cycles);

        // Integrator clamp at INTEG_LIMIT with constant error.
        restartLoop(16'h0300);
        for (int n = 0; n < 12; n++) begin
            applyStimulus(100, 0, 1, 16'h0300);
            waitForUpdate(cycles);
        end

        // Abort: drop enable during MUL_P of the next update.
        repeat (P - 4) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_duty",       longint'(bus.duty),       0);
        checkOutput("abort_direction",  longint'(bus.direction),  0);
        checkOutput("abort_saturated",  longint'(bus.saturated),  0);
        checkOutput("abort_duty_valid", longint'(bus.duty_valid), 0);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.duty_valid) seen++;
        end
        checkOutput("abort_no_update", longint'(seen), 0);

        // Encoder moves while disabled; first update sees zero velocity and a fresh integrator.
        restartLoop(16'h2000);
        applyStimulus(100, 16'h0100, 1, 16'h2000);
        waitForUpdate(cycles);

        checkOutput("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
